// File: rtl/ct_ifu_bht_pre_ctrl.sv
// ct_ifu_bht_pre_ctrl: BHT array access control (init sweep, reads, buffered 2-bit counter updates); ports: ifu read, rtu update, invalidate, array controls
module ct_ifu_bht_pre_ctrl (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        bht_inv_req,
  output logic        bht_inv_done,
  output logic        bht_busy,
  input  logic        ifu_bht_rd_vld,
  input  logic [9:0]  ifu_bht_rd_index,
  output logic        bht_rd_data_vld,
  output logic [63:0] bht_rd_data,
  input  logic        rtu_bht_upd_vld,
  input  logic [9:0]  rtu_bht_upd_index,
  input  logic [4:0]  rtu_bht_upd_sel,
  input  logic [1:0]  rtu_bht_upd_cnt,
  input  logic        rtu_bht_upd_taken,
  output logic        bht_upd_rdy,
  output logic        bht_pre_array_clk_en,
  output logic        bht_pred_array_cen_b,
  output logic        bht_pred_array_gwen,
  output logic [9:0]  bht_pred_array_index,
  output logic [63:0] bht_pred_array_din,
  output logic [63:0] bht_pred_bwen,
  input  logic [63:0] bht_pre_data_out
);
  typedef enum logic {INIT, IDLE} state_t;
  state_t      state;
  logic [9:0]  swc;
  logic [16:0] fifo [2];
  logic        wp, rp;
  logic [1:0]  cnt;
  logic [1:0]  upd_new;
  logic [16:0] head;
  logic        idle_ok, sweep, arr_rd, arr_wr, enq, deq;
  always_comb begin
    upd_new = rtu_bht_upd_taken ? ((rtu_bht_upd_cnt == 2'd3) ? 2'd3 : rtu_bht_upd_cnt + 2'd1)
                                : ((rtu_bht_upd_cnt == 2'd0) ? 2'd0 : rtu_bht_upd_cnt - 2'd1);
    head = fifo[rp];
    // the invalidate cycle itself issues no access: reads are dropped and the buffer is flushed
    idle_ok = !cpurst && state == IDLE && !bht_inv_req;
    sweep = !cpurst && state == INIT;
    arr_rd = idle_ok && ifu_bht_rd_vld;
    arr_wr = idle_ok && !ifu_bht_rd_vld && cnt != 2'd0;
    bht_upd_rdy = !cpurst && state == IDLE && !cnt[1];
    enq = rtu_bht_upd_vld && bht_upd_rdy;
    deq = arr_wr;
    bht_busy = cpurst || state == INIT;
    bht_pred_array_cen_b = !(sweep || arr_rd || arr_wr);
    bht_pred_array_gwen = !(sweep || arr_wr);
    bht_pre_array_clk_en = !bht_pred_array_cen_b;
    bht_pred_array_index = sweep ? swc : arr_rd ? ifu_bht_rd_index : head[16:7];
    bht_pred_array_din = sweep ? {32{2'b01}} : {32{head[1:0]}};
    bht_pred_bwen = sweep ? 64'h0 : arr_wr ? ~(64'h3 << {head[6:2], 1'b0}) : {64{1'b1}};
    bht_rd_data = bht_pre_data_out;
  end
  always_ff @(posedge forever_cpuclk) begin
    if (enq) fifo[wp] <= {rtu_bht_upd_index, rtu_bht_upd_sel, upd_new};
    if (cpurst) begin
      state <= INIT;
      swc <= 10'd0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      bht_rd_data_vld <= 1'b0;
      bht_inv_done <= 1'b0;
    end else begin
      bht_rd_data_vld <= arr_rd;
      bht_inv_done <= 1'b0;
      if (state == INIT) begin
        swc <= bht_inv_req ? 10'd0 : swc + 10'd1;
        if (!bht_inv_req && swc == 10'd1023) begin
          state <= IDLE;
          bht_inv_done <= 1'b1;
        end
      end else if (bht_inv_req) begin
        state <= INIT;
        swc <= 10'd0;
        wp <= 1'b0;
        rp <= 1'b0;
        cnt <= 2'd0;
      end else begin
        wp <= wp ^ enq;
        rp <= rp ^ deq;
        cnt <= cnt + {1'b0, enq} - {1'b0, deq};
      end
    end
  end
endmodule
